// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flex
// Brief    : Single-clock FIFO with standard/FWFT read, occupancy count,
//            almost-full/empty thresholds, sticky error flags and sync clear.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 3,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  c_depth_int = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth     = (ADDR_WIDTH + 1)'(c_depth_int);
    localparam logic [ADDR_WIDTH:0] c_afull     = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_aempty    = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] c_cnt_one   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [c_depth_int];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_write_ok;
    logic w_read_ok;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    // clr wins over both requests, so neither side may move a pointer or the array
    assign w_write_ok = w_en & ~w_full  & ~clr;
    assign w_read_ok  = r_en & ~w_empty & ~clr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_write_ok) r_wptr <= r_wptr + c_ptr_one;
            if (w_read_ok)  r_rptr <= r_rptr + c_ptr_one;
            case ({w_write_ok, w_read_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_en & w_full)  r_overflow  <= 1'b1;
            if (r_en & w_empty) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write_ok) r_mem[r_wptr] <= w_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; forced to zero while empty
            assign r_data  = w_empty ? '0 : r_mem[r_rptr];
            assign r_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rdata;
            logic                  r_rvalid;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (clr) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_read_ok;
                    if (w_read_ok) r_rdata <= r_mem[r_rptr];
                end
            end

            assign r_data  = r_rdata;
            assign r_valid = r_rvalid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_afull);
    assign almost_empty = (r_count <= c_aempty);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_flex
// Brief    : Self-checking bench: standard-mode vector table with a data
//            scoreboard, plus FWFT, threshold-boundary and reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_flex;

    typedef struct {
        logic        we;
        logic [31:0] wd;
        logic        re;
        logic        cl;
        int          cnt;
        logic        ovf;
        logic        udf;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clr, w_en, r_en;
    logic [31:0] w_data, r_data;
    logic        r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;

    logic        f_w_en, f_r_en;
    logic [31:0] f_w_data, f_r_data;
    logic        f_r_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0]  f_count;

    int          checks   = 0;
    int          failures = 0;
    vec_t        vecs[$];
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .FWFT(0),
                     .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_std (
        .clk(clk), .resetn(resetn), .clr(clr), .w_en(w_en), .w_data(w_data),
        .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow));

    sync_fifo_flex #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .FWFT(1),
                     .AFULL_THRESH(8), .AEMPTY_THRESH(0)) u_fw (
        .clk(clk), .resetn(resetn), .clr(1'b0), .w_en(f_w_en), .w_data(f_w_data),
        .r_en(f_r_en), .r_data(f_r_data), .r_valid(f_r_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] wd, input logic re,
                                input logic cl, input int cnt, input logic ovf, input logic udf);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.cl = cl; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic        exp_v;
        logic [31:0] exp_d;
        logic        wok, rok;
        exp_v = 1'b0;
        exp_d = '0;
        if (v.cl) begin
            mq.delete();
        end else begin
            wok = v.we && (mq.size() < 8);
            rok = v.re && (mq.size() > 0);
            if (rok) begin
                exp_d = mq.pop_front();
                exp_v = 1'b1;
            end
            if (wok) mq.push_back(v.wd);
        end
        w_en = v.we; w_data = v.wd; r_en = v.re; clr = v.cl;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d count", idx), 32'(count), 32'(v.cnt));
        chk($sformatf("v%0d empty", idx), 32'(empty), 32'(v.cnt == 0));
        chk($sformatf("v%0d full", idx), 32'(full), 32'(v.cnt == 8));
        chk($sformatf("v%0d almost_empty", idx), 32'(almost_empty), 32'(v.cnt <= 2));
        chk($sformatf("v%0d almost_full", idx), 32'(almost_full), 32'(v.cnt >= 6));
        chk($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.ovf));
        chk($sformatf("v%0d underflow", idx), 32'(underflow), 32'(v.udf));
        chk($sformatf("v%0d r_valid", idx), 32'(r_valid), 32'(exp_v));
        if (exp_v) chk($sformatf("v%0d r_data", idx), r_data, exp_d);
    endtask

    task automatic fstep(input logic we, input logic [31:0] wd, input logic re);
        f_w_en = we; f_w_data = wd; f_r_en = re;
        @(posedge clk);
        #1;
        f_w_en = 1'b0; f_r_en = 1'b0;
    endtask

    initial begin
        // Fill to full, overflow attempt, drain, underflow
        for (int i = 0; i < 8; i++) add(1, 32'hA0 + i, 0, 0, i + 1, 0, 0);
        add(1, 32'hFF, 0, 0, 8, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 7 - i, 1, 0);
        add(0, 0, 1, 0, 0, 1, 1);
        // 12 words interleaved through the 8-deep array to force pointer wrap
        add(1, 32'hB0, 0, 0, 1, 1, 1);
        add(1, 32'hB1, 0, 0, 2, 1, 1);
        for (int i = 2; i < 12; i++) add(1, 32'hB0 + i, 1, 0, 2, 1, 1);
        add(0, 0, 1, 0, 1, 1, 1);
        add(0, 0, 1, 0, 0, 1, 1);
        // Simultaneous read/write at full and mid-level
        add(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 32'hC0 + i, 0, 0, i + 1, 0, 0);
        add(1, 32'hD0, 1, 0, 7, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 6 - i, 1, 0);
        add(1, 32'hD1, 1, 0, 4, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 3 - i, 1, 0);
        // clr with a concurrent write, then prove nothing was stored
        for (int i = 0; i < 5; i++) add(1, 32'hE0 + i, 0, 0, i + 1, 1, 0);
        add(1, 32'hE5, 0, 1, 0, 0, 0);
        add(1, 32'hF0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 32'h60 + i, 0, 0, i + 1, 0, 0);

        resetn = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
        f_w_en = 1'b0; f_r_en = 1'b0; f_w_data = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst almost_empty", 32'(almost_empty), 32'd1);
        chk("rst count", 32'(count), 32'd0);
        chk("rst full", 32'(full), 32'd0);
        chk("rst almost_full", 32'(almost_full), 32'd0);
        chk("rst r_valid", 32'(r_valid), 32'd0);
        chk("rst r_data", r_data, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);
        w_en = 1'b0; r_en = 1'b0; clr = 1'b0;

        // Asynchronous reset in the middle of a clock period
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("arst count", 32'(count), 32'd0);
        chk("arst empty", 32'(empty), 32'd1);
        chk("arst full", 32'(full), 32'd0);
        chk("arst almost_empty", 32'(almost_empty), 32'd1);
        chk("arst almost_full", 32'(almost_full), 32'd0);
        chk("arst r_valid", 32'(r_valid), 32'd0);
        chk("arst r_data", r_data, 32'd0);
        chk("arst overflow", 32'(overflow), 32'd0);
        chk("arst underflow", 32'(underflow), 32'd0);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        // FWFT instance: head word presented without r_en
        chk("fw rst r_valid", 32'(f_r_valid), 32'd0);
        chk("fw rst empty", 32'(f_empty), 32'd1);
        fstep(1, 32'h11, 0);
        chk("fw first r_valid", 32'(f_r_valid), 32'd1);
        chk("fw first r_data", f_r_data, 32'h11);
        fstep(1, 32'h22, 0);
        chk("fw hold r_data", f_r_data, 32'h11);
        chk("fw count2", 32'(f_count), 32'd2);
        fstep(0, 0, 1);
        chk("fw pop1 r_data", f_r_data, 32'h22);
        chk("fw pop1 r_valid", 32'(f_r_valid), 32'd1);
        fstep(0, 0, 1);
        chk("fw pop2 r_valid", 32'(f_r_valid), 32'd0);
        chk("fw pop2 empty", 32'(f_empty), 32'd1);
        chk("fw underflow clear", 32'(f_underflow), 32'd0);

        // AFULL_THRESH=DEPTH and AEMPTY_THRESH=0 collapse onto full/empty
        chk("fw bnd almost_empty", 32'(f_almost_empty), 32'd1);
        for (int i = 0; i < 8; i++) begin
            fstep(1, 32'h30 + i, 0);
            chk($sformatf("fw fill%0d almost_full", i), 32'(f_almost_full), 32'(i == 7));
            chk($sformatf("fw fill%0d almost_empty", i), 32'(f_almost_empty), 32'd0);
        end
        chk("fw full", 32'(f_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fw drain%0d r_data", i), f_r_data, 32'h30 + i);
            fstep(0, 0, 1);
            chk($sformatf("fw drain%0d almost_full", i), 32'(f_almost_full), 32'd0);
        end
        chk("fw end almost_empty", 32'(f_almost_empty), 32'd1);
        chk("fw end overflow", 32'(f_overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO; the same-clock counterpart to the dual-clock pointer FIFO in the Pipelined_CPU buffering path.
- Used between pipeline stages and peripherals that share one clock.
- Adds behaviour the earlier FIFO lacks:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - occupancy count
  - almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - synchronous clear

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8).
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through.
- AFULL_THRESH, 6, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; flushes the FIFO.
- w_en  input  1  write request.
- w_data  input  DATA_WIDTH  write data.
- r_en  input  1  read request.
- r_data  output  DATA_WIDTH  read data.
- r_valid  output  1  r_data holds a valid word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (resetn=0, asynchronous):
  - write pointer, read pointer and count = 0
  - r_data = 0, r_valid = 0, overflow = 0, underflow = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - memory array is not reset.
- Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 naturally.
- Status flags are decoded from the registered count; the flags and count reflect every accepted operation on the following cycle.
- Write acceptance: write_ok = w_en & ~full. On write_ok, mem[wptr] <= w_data and wptr increments.
- Read acceptance: read_ok = r_en & ~empty. On read_ok, rptr increments.
- Count update:
  - +1 on write_ok only
  - -1 on read_ok only
  - unchanged when both or neither occur.
- Simultaneous read and write:
  - When full, only the read is accepted; the write is dropped and overflow is set.
  - When empty, only the write is accepted; underflow is set.
- Error flags:
  - overflow <= 1 when w_en & full; underflow <= 1 when r_en & empty.
  - Both hold until clr or reset.
- Standard mode (FWFT=0):
  - On read_ok, r_data <= mem[rptr] at the next edge, and r_valid pulses high for exactly that one cycle.
  - r_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - r_data = mem[rptr] continuously and r_valid = ~empty.
  - r_en acknowledges (pops) the presented word; the next word appears the cycle after read_ok.
  - After the first write into an empty FIFO, r_valid rises the following cycle.
- clr (synchronous):
  - Has priority over w_en and r_en in the same cycle.
  - Zeroes pointers, count, r_valid, overflow and underflow.
  - r_data holds its value in standard mode.
- Reset mid-operation: asserting resetn low takes effect immediately regardless of clk; no partial write may corrupt the pointers.
- Threshold boundaries:
  - AFULL_THRESH = DEPTH makes almost_full equal to full.
  - AEMPTY_THRESH = 0 makes almost_empty equal to empty.

Test Plan:
- Reset, defaults (FWFT=0): after resetn release, check empty=1, almost_empty=1, count=0, full=0, r_valid=0, r_data=0. Then write 0xA0..0xA7 on 8 consecutive cycles. Required:
  - almost_empty drops when count reaches 3.
  - almost_full rises when count reaches 6.
  - full=1 and count=8 after the 8th write.
- Overflow: with the FIFO full, write 0xFF. Required: count stays 8 and overflow=1 (sticky). Then read 8 words. Required:
  - r_data = 0xA0..0xA7 in order, each one cycle after its r_en
  - r_valid pulsing each time
  - empty=1 at the end; the 0xFF word is never read out.
- Underflow and wrap: with the FIFO empty, pulse r_en. Required: underflow=1, count=0. Then write and read 12 words through the 8-deep FIFO in interleaved fashion. Required: pointer wrap without data loss and in-order data.
- Simultaneous operations:
  - At count=8, assert w_en and r_en together. Required: read accepted, write dropped, count=7, overflow=1.
  - At count=4, assert both. Required: count stays 4 and order is preserved.
- FWFT=1: write 0x11, then 0x22. Required: r_valid=1 and r_data=0x11 without r_en. After one r_en cycle, r_data=0x22. After a second r_en, r_valid=0 and empty=1.
- clr and async reset:
  - With count=5 and overflow=1, assert clr together with w_en. Required next cycle: count=0, empty=1, overflow=0, and no word written.
  - Refill to 3 words, then drop resetn mid-cycle. Required: immediate count=0 and all flags at reset values.
